activity_sensor_sampler: RTL and testbench
==========================================

Name: activity_sensor_sampler

Overview:
Upstream front-end for the step calculator. Converts raw heartbeat and footfall pulses into per-second samples. Each second it produces a heart rate in BPM (hr_out) and a steps-per-second value (sps_out), plus a one-cycle valid_out strobe. hr_out, sps_out and valid_out connect directly to the step calculator's hr_input, steps_per_second and valid_input.

Parameters:
SEC_CYCLES, 100, clock cycles per one-second window (100 for simulation, 100_000_000 for silicon).
HR_BINS, 6, number of one-second beat bins in the sliding heart-rate window; must divide 60.
BIN_W, 4, width of each beat bin; a bin saturates at 2^BIN_W-1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  sampling enable, level
beat_in  input  1  raw asynchronous heartbeat pulse; high and low phases each last at least 2 cycles
step_in  input  1  raw asynchronous footfall pulse; same timing rule as beat_in
hr_out  output  8  heart rate in BPM, saturating
sps_out  output  2  steps in the last second, saturating
valid_out  output  1  one-cycle strobe marking new hr_out and sps_out
sensor_fault  output  1  no beats seen across the whole window

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, all counters, bins and sum cleared, synchronizers cleared. A reset mid-operation takes effect immediately; any in-flight window is lost.
- Input path: beat_in and step_in each pass through a 2-flop synchronizer and a rising-edge detector. An event is counted 3 cycles after the raw rising edge.
- States:
  - IDLE: tick, bins, sum, filled count and step count are held at 0. hr_out and sps_out hold their last values. valid_out=0. enable=1 moves to WARMUP on the next cycle.
  - WARMUP: tick runs. At each boundary, filled increments. When the HR_BINS-th boundary occurs, the state moves to RUN.
  - RUN: tick runs. Every boundary produces an output.
  - enable=0 in WARMUP or RUN returns to IDLE on the next cycle. Re-enabling restarts a full warmup.
- Tick counter: starts at 0 on the first cycle in WARMUP, counts 0..SEC_CYCLES-1, then wraps. The boundary is the cycle where tick==SEC_CYCLES-1.
- Event counting:
  - Beat events increment the current bin, saturating at 2^BIN_W-1.
  - Step events increment a 4-bit step counter, saturating at 15.
  - An event detected on the boundary cycle counts into the closing second.
- At each boundary:
  - The current bin is shifted into the bin history.
  - Running sum updates as sum = sum + new − oldest (oldest is 0 until the history is filled).
  - The current bin and step counter are cleared for the next second.
- Output (RUN, including the boundary that completes warmup):
  - On the cycle after the boundary: hr_out = min(sum*(60/HR_BINS), 255) and sps_out = min(step_count, 3).
  - valid_out=1 for exactly that one cycle.
  - In WARMUP, no valid_out is produced and hr_out/sps_out are not updated.
- Output latency: enable is sampled high at cycle 0, so the first valid_out is at cycle 1+HR_BINS*SEC_CYCLES.
- sensor_fault: evaluated at each RUN boundary. It is set when sum==0 and cleared when sum>0, and is updated together with valid_out. It holds its value in IDLE.
- Arithmetic widths:
  - Sum width is clog2(HR_BINS*(2^BIN_W-1)+1).
  - The product is computed wide and then saturated to 8 bits.
  - Steps are saturated, never truncated; a value of 4 reports as 3.

Decomposition:
- Shared package (activity_pkg) holds:
  - the IDLE/WARMUP/RUN state enum;
  - the BPM multiplier constant 60/HR_BINS;
  - the HR_MAX=255 and SPS_MAX=3 saturation constants.
- One sub-module, pulse_edge_sync (2-flop synchronizer plus rising-edge detector, rst async active-low), instantiated once each for beat_in and step_in.

Test Plan (SEC_CYCLES=100, HR_BINS=6, BIN_W=4):
1. Reset: assert rst=0 mid-run -> all outputs 0 immediately, including hr_out, and no valid_out until a full 600-cycle warmup has completed after release.
2. Nominal: enable=1, beats and steps every 50 cycles (2/s) -> first valid_out at cycle 601 with hr_out=120, sps_out=2, sensor_fault=0; then exactly one strobe every 100 cycles.
3. Saturation: steps 5/s and beats 20/s -> bins saturate at 15, sum=90 gives a computed 900 -> hr_out=255, sps_out=3.
4. Dropout: from steady 2 beats/s, stop beats -> hr_out steps 100, 80, 60, 40, 20, 0 on successive strobes, with sensor_fault=1 at the 0 strobe; resume beats -> sensor_fault clears on the first strobe where sum>0.
5. Enable abort: drop enable at cycle 350 of warmup, re-enable -> no valid_out before a fresh 600-cycle warmup completes.
6. Boundary edge: a beat detected exactly on the tick==99 cycle -> counted in the closing second (hr_out higher by 10 for the next 6 strobes versus the same beat one cycle later).

Source files
------------

// File: rtl/activity_pkg.sv
// activity_pkg: shared FSM states, BPM multiplier helper and output saturation limits for activity_sensor_sampler
package activity_pkg;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  localparam logic [7:0] HR_MAX = 8'd255;
  localparam logic [1:0] SPS_MAX = 2'd3;
  function automatic int bpm_mult(input int hr_bins);
    return 60 / hr_bins;
  endfunction
endpackage

// File: rtl/pulse_edge_sync.sv
// pulse_edge_sync: 2-flop synchronizer plus rising-edge detector (clk, rst async active-low, pulse raw in, rise one-cycle event)
module pulse_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else sr <= {sr[1:0], pulse};
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/activity_sensor_sampler.sv
// activity_sensor_sampler: per-second heart-rate/steps sampler (clk, rst async active-low, enable, beat_in, step_in -> hr_out, sps_out, valid_out, sensor_fault)
module activity_sensor_sampler
  import activity_pkg::*;
#(
  parameter int SEC_CYCLES = 100,
  parameter int HR_BINS    = 6,
  parameter int BIN_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       beat_in,
  input  logic       step_in,
  output logic [7:0] hr_out,
  output logic [1:0] sps_out,
  output logic       valid_out,
  output logic       sensor_fault
);
  localparam int SUM_W  = $clog2(HR_BINS * (2 ** BIN_W - 1) + 1);
  localparam int TICK_W = $clog2(SEC_CYCLES + 1);
  localparam int FILL_W = $clog2(HR_BINS + 1);
  localparam int MULT   = bpm_mult(HR_BINS);
  localparam logic [BIN_W-1:0] BIN_MAX = '1;
  state_t                       state;
  logic [TICK_W-1:0]            tick;
  logic [FILL_W-1:0]            filled;
  logic [BIN_W-1:0]             cur, cur_nx;
  logic [3:0]                   steps, steps_nx;
  logic [HR_BINS-1:0][BIN_W-1:0] hist;
  logic [SUM_W-1:0]             sum, sum_nx;
  logic [31:0]                  prod;
  logic                         beat_rise, step_rise, boundary, last_fill;
  pulse_edge_sync u_beat (.clk(clk), .rst(rst), .pulse(beat_in), .rise(beat_rise));
  pulse_edge_sync u_step (.clk(clk), .rst(rst), .pulse(step_in), .rise(step_rise));
  assign boundary  = tick == TICK_W'(SEC_CYCLES - 1);
  assign last_fill = state == WARMUP && filled == FILL_W'(HR_BINS - 1);
  assign cur_nx    = cur + BIN_W'(beat_rise && cur != BIN_MAX);
  assign steps_nx  = steps + 4'(step_rise && steps != 4'hf);
  assign sum_nx    = sum + SUM_W'(cur_nx) - SUM_W'(hist[HR_BINS-1]);
  assign prod      = 32'(sum_nx) * 32'(MULT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      tick         <= '0;
      filled       <= '0;
      cur          <= '0;
      steps        <= '0;
      hist         <= '0;
      sum          <= '0;
      hr_out       <= '0;
      sps_out      <= '0;
      valid_out    <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE || !enable) begin
        state  <= enable ? WARMUP : IDLE;
        tick   <= '0;
        filled <= '0;
        cur    <= '0;
        steps  <= '0;
        hist   <= '0;
        sum    <= '0;
      end else begin
        tick  <= boundary ? '0 : tick + TICK_W'(1);
        cur   <= boundary ? '0 : cur_nx;
        steps <= boundary ? '0 : steps_nx;
        if (boundary) begin
          hist <= {hist[HR_BINS-2:0], cur_nx};
          sum  <= sum_nx;
          if (state == WARMUP) filled <= filled + FILL_W'(1);
          if (last_fill) state <= RUN;
          if (state == RUN || last_fill) begin
            hr_out       <= prod > 32'(HR_MAX) ? HR_MAX : prod[7:0];
            sps_out      <= steps_nx > 4'(SPS_MAX) ? SPS_MAX : steps_nx[1:0];
            valid_out    <= 1'b1;
            sensor_fault <= sum_nx == '0;
          end
        end
      end
    end
endmodule

// File: tb/tb_activity_sensor_sampler.sv
// tb_activity_sensor_sampler: scoreboard bench with a per-second window reference model for activity_sensor_sampler
module tb_activity_sensor_sampler;
  localparam int SEC = 100, BINS = 6, BW = 4, MUL = 60 / BINS, BMAX = (1 << BW) - 1;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, beat_in = 1'b0, step_in = 1'b0;
  logic [7:0] hr_out;
  logic [1:0] sps_out;
  logic valid_out, sensor_fault;
  activity_sensor_sampler #(.SEC_CYCLES(SEC), .HR_BINS(BINS), .BIN_W(BW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .beat_in(beat_in), .step_in(step_in),
    .hr_out(hr_out), .sps_out(sps_out), .valid_out(valid_out), .sensor_fault(sensor_fault)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; int hr; int sps; bit fault;} exp_t;
  exp_t sb[$];
  exp_t e;
  int det_b[$], det_s[$], win[$];
  int t = 0, t0 = 0, cur_b = 0, cur_s = 0, n_chk = 0, n_fail = 0, n_strobe = 0, n_exp = 0;
  int b_age = 1000, s_age = 1000, b_per = 4, s_per = 4;
  int last_hr = 0, last_sps = 0, last_fault = 0;
  bit running = 1'b0, mon_on = 1'b0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask
  task automatic pulse(input int per, input bit kick, inout int age, inout int p, output logic pin);
    if (kick || (per != 0 && age >= p)) begin
      age = 0;
      p = per > 0 ? per : int'($urandom_range(4, 40));
    end else if (age < 1000) age++;
    pin = age < 2;
  endtask
  task automatic cyc(input bit en, input int bp, input int sp, input bit kick);
    logic pb, ps;
    bit db, ds;
    int k, sum;
    @(posedge clk);
    #1;
    t++;
    pb = beat_in;
    ps = step_in;
    enable = en;
    pulse(bp, kick, b_age, b_per, beat_in);
    pulse(sp, 1'b0, s_age, s_per, step_in);
    if (beat_in && !pb) det_b.push_back(t + 2);
    if (step_in && !ps) det_s.push_back(t + 2);
    db = det_b.size() > 0 && det_b[0] == t;
    ds = det_s.size() > 0 && det_s[0] == t;
    if (db) void'(det_b.pop_front());
    if (ds) void'(det_s.pop_front());
    if (!en || !rst) running = 1'b0;
    else if (!running) begin
      running = 1'b1;
      t0 = t;
      cur_b = 0;
      cur_s = 0;
      win.delete();
    end else begin
      k = (t - t0 - 1) / SEC;
      cur_b += int'(db);
      cur_s += int'(ds);
      if (t == t0 + SEC * (k + 1)) begin
        win.push_back(cur_b > BMAX ? BMAX : cur_b);
        if (win.size() > BINS) void'(win.pop_front());
        if (k >= BINS - 1) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          sb.push_back('{t + 1, sum * MUL > 255 ? 255 : sum * MUL, cur_s > 3 ? 3 : cur_s, sum == 0});
          n_exp++;
        end
        cur_b = 0;
        cur_s = 0;
      end
    end
  endtask
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    t++;
    enable = 1'b0;
    #2;
    rst = 1'b0;
    running = 1'b0;
    sb.delete();
    det_b.delete();
    det_s.delete();
    last_hr = 0;
    last_sps = 0;
    last_fault = 0;
    #1;
    check("rst_hr_out", int'(hr_out), 0);
    check("rst_sps_out", int'(sps_out), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_sensor_fault", int'(sensor_fault), 0);
    repeat (n) cyc(1'b0, 0, 0, 1'b0);
    rst = 1'b1;
  endtask
  always @(negedge clk) if (mon_on) begin
    while (sb.size() > 0 && sb[0].cyc < t) begin
      check("missing_strobe_cycle", t, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (valid_out) begin
      n_strobe++;
      if (sb.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        check("strobe_cycle", t, e.cyc);
        check("hr_out", int'(hr_out), e.hr);
        check("sps_out", int'(sps_out), e.sps);
        check("sensor_fault", int'(sensor_fault), int'(e.fault));
        last_hr = e.hr;
        last_sps = e.sps;
        last_fault = int'(e.fault);
      end
    end else begin
      check("hr_hold", int'(hr_out), last_hr);
      check("sps_hold", int'(sps_out), last_sps);
      check("fault_hold", int'(sensor_fault), last_fault);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", t);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    mon_on = 1'b1;
    check("init_hr_out", int'(hr_out), 0);
    check("init_valid_out", int'(valid_out), 0);
    rst = 1'b1;
    repeat (1000) cyc(1'b1, 50, 50, 1'b0);
    repeat (800) cyc(1'b1, 5, 20, 1'b0);
    repeat (10) cyc(1'b1, 0, 0, 1'b0);
    do_reset(3);
    repeat (700) cyc(1'b1, 50, 50, 1'b0);
    repeat (800) cyc(1'b1, 0, 50, 1'b0);
    repeat (300) cyc(1'b1, 50, 50, 1'b0);
    repeat (5) cyc(1'b0, 50, 50, 1'b0);
    repeat (350) cyc(1'b1, 50, 50, 1'b0);
    repeat (5) cyc(1'b0, 50, 50, 1'b0);
    repeat (700) cyc(1'b1, -1, -1, 1'b0);
    repeat (5) cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b1, 0, 0, 1'b0);
    while (t < t0 + SEC * 8 - 3) cyc(1'b1, 0, 0, 1'b0);
    cyc(1'b1, 0, 0, 1'b1);
    while (t < t0 + SEC * 15 - 2) cyc(1'b1, 0, 0, 1'b0);
    cyc(1'b1, 0, 0, 1'b1);
    while (t < t0 + SEC * 23) cyc(1'b1, 0, 0, 1'b0);
    repeat (1500) cyc(1'b1, -1, -1, 1'b0);
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    check("scoreboard_drained", sb.size(), 0);
    check("strobe_count", n_strobe, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
